// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   OVERSAMPLE_DEF / DATA_BITS_DEF : defaults shared by pfracbrg, uart_tx and uart_rx_os
//   rx_state_t                     : receiver frame state
//   maj3()                         : 2-of-3 majority vote
package uart_pkg;

   localparam int unsigned OVERSAMPLE_DEF = 16;
   localparam int unsigned DATA_BITS_DEF  = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Line conditioner for the UART receiver.
//   clk_i, rst_i (async, active-high), clr_i (sync clear)
//   os_stb_i : oversample strobe; sample history advances only on it
//   rxd_i    : asynchronous serial line, idle high
//   sample_o : synchronised line value
//   vote_o   : majority of the current sample and the two previous strobe samples
module uart_rx_sync
   import uart_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic os_stb_i,
   input  logic rxd_i,
   output logic sample_o,
   output logic vote_o
);

   logic [1:0] sync;
   logic [1:0] hist;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync <= '1;
         hist <= '1;
      end else if (clr_i) begin
         sync <= '1;
         hist <= '1;
      end else begin
         sync <= {sync[0], rxd_i};
         if (os_stb_i)
            hist <= {hist[0], sync[1]};
      end
   end

   assign sample_o = sync[1];
   // The newest tap is the live synchronised sample, so the vote taken on a
   // strobe covers that strobe and the two before it.
   assign vote_o   = maj3({hist, sync[1]});

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver.
//   clk_i, rst_i (async, active-high), clr_i (sync clear, same effect as reset)
//   os_stb_i : 1-of-OVERSAMPLE strobe from the baud generator
//   rxd_i    : asynchronous serial line, idle high
//   dat_o    : received word, held while vld_o
//   vld_o    : word available; taken when vld_o & rdy_i
//   rdy_i    : consumer ready
//   ferr_o   : stop bit sampled 0 for dat_o
//   perr_o   : parity mismatch for dat_o (0 when parity disabled)
//   ovr_o    : 1-cycle pulse, completed frame dropped because holding reg full
//   busy_o   : frame reception in progress
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = 0
)(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clr_i,
   input  logic                 os_stb_i,
   input  logic                 rxd_i,
   output logic [DATA_BITS-1:0] dat_o,
   output logic                 vld_o,
   input  logic                 rdy_i,
   output logic                 ferr_o,
   output logic                 perr_o,
   output logic                 ovr_o,
   output logic                 busy_o
);

   localparam int unsigned SCW = $clog2(OVERSAMPLE);
   localparam int unsigned BCW = $clog2(DATA_BITS);
   localparam logic [SCW-1:0] SC_MID  = SCW'(OVERSAMPLE / 2);
   localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
   localparam logic [SCW-1:0] SC_ONE  = SCW'(1);
   localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS - 1);
   localparam logic           ODD     = (PARITY_ODD != 0);

   rx_state_t            state, state_n;
   logic [SCW-1:0]       sc, sc_n;
   logic [BCW-1:0]       bc, bc_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic                 perr_acc, perr_acc_n;
   logic                 armed, armed_n;
   logic                 commit, commit_ferr;
   logic                 sample, vote;

   uart_rx_sync u_sync (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (clr_i),
      .os_stb_i (os_stb_i),
      .rxd_i    (rxd_i),
      .sample_o (sample),
      .vote_o   (vote)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         sc       <= '0;
         bc       <= '0;
         shreg    <= '0;
         perr_acc <= 1'b0;
         armed    <= 1'b1;
      end else if (clr_i) begin
         state    <= IDLE;
         sc       <= '0;
         bc       <= '0;
         shreg    <= '0;
         perr_acc <= 1'b0;
         armed    <= 1'b1;
      end else begin
         state    <= state_n;
         sc       <= sc_n;
         bc       <= bc_n;
         shreg    <= shreg_n;
         perr_acc <= perr_acc_n;
         armed    <= armed_n;
      end
   end

   always_comb begin
      state_n     = state;
      sc_n        = sc;
      bc_n        = bc;
      shreg_n     = shreg;
      perr_acc_n  = perr_acc;
      armed_n     = armed;
      commit      = 1'b0;
      commit_ferr = 1'b0;
      if (os_stb_i) begin
         // A break leaves the line low after its framing-error frame; a new
         // start is only accepted once a 1 has been seen again.
         if (sample)
            armed_n = 1'b1;
         sc_n = (sc == SC_LAST) ? '0 : sc + SC_ONE;
         unique case (state)
            IDLE: begin
               sc_n = '0;
               if (armed && !sample) begin
                  state_n    = START;
                  sc_n       = SC_ONE;
                  perr_acc_n = 1'b0;
               end
            end
            START: begin
               if (sc == SC_MID && vote) begin
                  state_n = IDLE;
                  sc_n    = '0;
               end else if (sc == SC_LAST) begin
                  state_n = DATA;
                  bc_n    = '0;
               end
            end
            DATA: begin
               if (sc == SC_MID)
                  shreg_n = {vote, shreg[DATA_BITS-1:1]};
               if (sc == SC_LAST) begin
                  if (bc == BC_LAST) begin
                     bc_n    = '0;
                     state_n = (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                     bc_n = bc + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (sc == SC_MID)
                  perr_acc_n = (vote != ((^shreg) ^ ODD));
               if (sc == SC_LAST)
                  state_n = STOP;
            end
            STOP: begin
               // Leave at mid-stop so the next start edge is searched for
               // with half a bit of slack.
               if (sc == SC_MID) begin
                  commit      = 1'b1;
                  commit_ferr = !vote;
                  if (!vote)
                     armed_n = 1'b0;
                  state_n = IDLE;
                  sc_n    = '0;
               end
            end
            default: begin
               state_n = IDLE;
               sc_n    = '0;
            end
         endcase
      end
   end

   // Holding register: an accept and a new commit in the same cycle load
   // the new word; a commit against an unaccepted word is dropped.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dat_o  <= '0;
         vld_o  <= 1'b0;
         ferr_o <= 1'b0;
         perr_o <= 1'b0;
         ovr_o  <= 1'b0;
      end else if (clr_i) begin
         dat_o  <= '0;
         vld_o  <= 1'b0;
         ferr_o <= 1'b0;
         perr_o <= 1'b0;
         ovr_o  <= 1'b0;
      end else begin
         ovr_o <= 1'b0;
         if (commit) begin
            if (!vld_o || rdy_i) begin
               dat_o  <= shreg;
               ferr_o <= commit_ferr;
               perr_o <= perr_acc;
               vld_o  <= 1'b1;
            end else begin
               ovr_o <= 1'b1;
            end
         end else if (vld_o && rdy_i) begin
            vld_o <= 1'b0;
         end
      end
   end

   assign busy_o = (state != IDLE);

endmodule
